// File: rtl/npu_pkg.sv
// Shared geometry, width constants and the ReLU/requantise helper for the conv1/pool1 path.
// Define POOL1_ROUND_EN to round half-up before the shift instead of truncating.
package npu_pkg;

  localparam int IN_H   = 14;
  localparam int IN_W   = 13;
  localparam int OUT_H  = IN_H / 2;
  localparam int OUT_W  = IN_W / 2;
  localparam int CHAN   = 10;
  localparam int CHAN_W = 4;
  localparam int SHIFT  = 8;
  localparam int ACT_W  = 8;
  localparam int ACC_W  = 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POOL = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [ACT_W-1:0] requant_relu(input logic signed [ACC_W-1:0] x);
    logic [ACC_W:0] t;
    logic [ACC_W:0] y;
    t = {1'b0, x};
`ifdef POOL1_ROUND_EN
    t = t + (ACC_W+1)'(1 << (SHIFT - 1));
`endif
    y = t >> SHIFT;
    if (x[ACC_W-1])
      return '0;
    else if (y > (ACC_W+1)'((1 << ACT_W) - 1))
      return '1;
    else
      return y[ACT_W-1:0];
  endfunction

endpackage

// File: rtl/max4_u8.sv
// Combinational unsigned maximum of four 8-bit activations (one 2x2 pooling window).
module max4_u8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [7:0] c,
  input  logic [7:0] d,
  output logic [7:0] y
);

  logic [7:0] m_ab;
  logic [7:0] m_cd;

  assign m_ab = (a > b) ? a : b;
  assign m_cd = (c > d) ? c : d;
  assign y    = (m_ab > m_cd) ? m_ab : m_cd;

endmodule

// File: rtl/pool1.sv
// Conv1 output stage: ReLU + requantise snapshot, 2x2/stride-2 max-pool, per-channel fmap bank.
// Rounding of the requantiser is selected by POOL1_ROUND_EN (see npu_pkg).
module pool1
  import npu_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [CHAN_W-1:0]       in_chan,
  input  logic signed [ACC_W-1:0] in_buff  [IN_H][IN_W],
  output logic [ACT_W-1:0]        out_fmap [CHAN][OUT_H][OUT_W],
  output logic                    out_valid,
  output logic [CHAN_W-1:0]       out_chan,
  output logic                    all_done,
  output logic                    busy,
  output logic                    overrun
);

  state_t            state, state_next;
  logic [ACT_W-1:0]  snap [IN_H][IN_W];
  logic [CHAN_W-1:0] cur_chan;
  logic              chan_ok;
  logic [2:0]        row, col;
  logic              last_px;
  logic [ACT_W-1:0]  pool_max;

  assign busy    = (state != IDLE);
  assign last_px = (row == 3'(OUT_H - 1)) && (col == 3'(OUT_W - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = POOL;
      POOL:    if (last_px)  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_chan  <= '0;
      chan_ok   <= 1'b0;
      row       <= '0;
      col       <= '0;
      out_valid <= 1'b0;
      all_done  <= 1'b0;
      out_chan  <= '0;
      overrun   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      all_done  <= 1'b0;
      if (busy && in_valid) overrun <= 1'b1;
      case (state)
        IDLE: if (in_valid) begin
          cur_chan <= in_chan;
          chan_ok  <= (in_chan < CHAN_W'(CHAN));
          row      <= '0;
          col      <= '0;
        end
        POOL: begin
          if (col == 3'(OUT_W - 1)) begin
            col <= '0;
            row <= row + 3'd1;
          end else begin
            col <= col + 3'd1;
          end
        end
        DONE: begin
          out_valid <= 1'b1;
          out_chan  <= cur_chan;
          all_done  <= (cur_chan == CHAN_W'(CHAN - 1));
        end
        default: ;
      endcase
    end
  end

  // in_buff is only stable during the in_valid cycle, so everything is requantised at once.
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      for (int r = 0; r < IN_H; r++)
        for (int c = 0; c < IN_W; c++)
          snap[r][c] <= requant_relu(in_buff[r][c]);
    end
  end

  max4_u8 u_max4 (
    .a (snap[{row, 1'b0}][{col, 1'b0}]),
    .b (snap[{row, 1'b0}][{col, 1'b1}]),
    .c (snap[{row, 1'b1}][{col, 1'b0}]),
    .d (snap[{row, 1'b1}][{col, 1'b1}]),
    .y (pool_max)
  );

  // Out-of-range channels are pooled for timing but never land in the bank.
  always_ff @(posedge clk) begin
    if (!rst && state == POOL && chan_ok)
      out_fmap[cur_chan][row][col] <= pool_max;
  end

endmodule
